// File: rtl/frm_wr.sv
// frm_wr - frame write requester feeding the AXI arbiter's shared frame FIFO.
//
// Buffers an incoming 32-bit word stream locally and slices each frame into
// bursts of at most BST_LEN words. Every burst requests the arbiter, then
// pushes a command word, an address word and the burst data into the frame
// FIFO. frm_done pulses once the arbiter reports the last burst complete.
//
// Optional build macro:
//   FRM_WR_BSWAP_EN  byte-swap data words on the way out (command and
//                    address words are never swapped).
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start            frame start pulse (sampled only in IDLE)
//   base_addr        frame byte address (4-byte aligned)
//   num_words        frame length in 32-bit words
//   busy             state is not IDLE
//   frm_done         one-cycle frame completion pulse
//   s_valid/s_ready  input word handshake, s_data input word
//   req/ack          arbiter request / registered grant
//   valid_out        frame FIFO write enable
//   data_out         frame FIFO data
//   strb_out         frame FIFO byte strobe (always 4'hF)
//   done_in          arbiter completion pulse for this requester
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start with a non-zero frame length
// S_FILL    | waiting for a full burst in the buffer and a released grant
// S_REQ     | requesting the arbiter, waiting for ack
// S_CMD     | pushing the command word
// S_ADDR    | pushing the burst address word
// S_DATA    | popping and pushing cur_len data words
// S_WAIT    | all bursts pushed, waiting for done_in

module frm_wr #(
  parameter int BST_LEN = 16,
  parameter int BUF_AW  = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [23:0] num_words,
  output logic        busy,
  output logic        frm_done,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        req,
  input  logic        ack,
  output logic        valid_out,
  output logic [31:0] data_out,
  output logic [3:0]  strb_out,
  input  logic        done_in
);

  localparam int DEPTH = 1 << BUF_AW;
  localparam int CW    = BUF_AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_REQ,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [31:0]       mem [DEPTH];
  logic [BUF_AW-1:0] wr_ptr;
  logic [BUF_AW-1:0] rd_ptr;
  logic [CW-1:0]     buf_cnt;

  logic [31:0] cur_addr;
  logic [23:0] remaining;
  logic [8:0]  beat_left;
  logic [8:0]  cur_len;
  logic        last_bst;
  logic        fill_ok;
  logic        beat_last;
  logic        push;
  logic        pop;

  logic        req_nxt;
  logic        valid_nxt;
  logic [31:0] data_nxt;

  function automatic logic [31:0] swap_data(input logic [31:0] d);
`ifdef FRM_WR_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  assign cur_len   = (remaining > 24'(BST_LEN)) ? 9'(BST_LEN) : remaining[8:0];
  assign last_bst  = (remaining == 24'(cur_len));
  assign fill_ok   = (32'(buf_cnt) >= 32'(cur_len));
  assign beat_last = (beat_left == 9'd1);

  assign s_ready = (buf_cnt != CW'(DEPTH));
  assign push    = s_valid & s_ready;
  assign pop     = (state == S_DATA);
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = 1'b0;
    valid_nxt = 1'b0;
    data_nxt  = data_out;
    unique case (state)
      S_IDLE: begin
        if (start && (num_words != '0)) state_nxt = S_FILL;
      end
      S_FILL: begin
        // A grant still high from the previous burst must not be reused.
        if (fill_ok && !ack) state_nxt = S_REQ;
      end
      S_REQ: begin
        req_nxt = 1'b1;
        if (ack) state_nxt = S_CMD;
      end
      S_CMD: begin
        req_nxt   = 1'b1;
        valid_nxt = 1'b1;
        data_nxt  = {22'b0, last_bst, 1'b0, 8'(cur_len - 9'd1)};
        state_nxt = S_ADDR;
      end
      S_ADDR: begin
        req_nxt   = 1'b1;
        valid_nxt = 1'b1;
        data_nxt  = cur_addr;
        state_nxt = S_DATA;
      end
      S_DATA: begin
        req_nxt   = 1'b1;
        valid_nxt = 1'b1;
        data_nxt  = swap_data(mem[rd_ptr]);
        if (beat_last) state_nxt = last_bst ? S_WAIT : S_FILL;
      end
      S_WAIT: begin
        if (done_in) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Buffer storage has no reset; the pointers and count define its content.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_cnt   <= '0;
      cur_addr  <= '0;
      remaining <= '0;
      beat_left <= '0;
      req       <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
      strb_out  <= 4'hF;
      frm_done  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + BUF_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + BUF_AW'(1);
      unique case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + CW'(1);
        2'b01:   buf_cnt <= buf_cnt - CW'(1);
        default: buf_cnt <= buf_cnt;
      endcase

      if ((state == S_IDLE) && (state_nxt == S_FILL)) begin
        cur_addr  <= base_addr;
        remaining <= num_words;
      end

      if (state == S_ADDR) beat_left <= cur_len;

      if (state == S_DATA) begin
        beat_left <= beat_left - 9'd1;
        if (beat_last) begin
          cur_addr  <= cur_addr + {21'b0, cur_len, 2'b00};
          remaining <= remaining - 24'(cur_len);
        end
      end

      req       <= req_nxt;
      valid_out <= valid_nxt;
      data_out  <= data_nxt;
      strb_out  <= 4'hF;
      frm_done  <= (state == S_WAIT) && done_in;
    end
  end

endmodule

// File: tb/tb_frm_wr.sv
module tb_frm_wr;

  localparam int BST = 16;
  localparam int AW  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [23:0] num_words = '0;
  logic        busy;
  logic        frm_done;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        req;
  logic        ack = 1'b0;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  strb_out;
  logic        done_in = 1'b0;

  frm_wr #(.BST_LEN(BST), .BUF_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .frm_done(frm_done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .req(req), .ack(ack), .valid_out(valid_out), .data_out(data_out),
    .strb_out(strb_out), .done_in(done_in)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  logic [31:0] in_q[$];
  bit sb_on = 1'b1;
  int fed = 0;
  int feed_limit = 1 << 30;
  int gap_pct = 20;
  bit ack_en = 1'b1;
  int ack_dly = 2;
  int stale_extra = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bsw(input logic [31:0] d);
`ifdef FRM_WR_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every FIFO push is compared against the model queue.
  logic prev_ack = 1'b0;
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (sb_on && rst_n) begin
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL push_unexpected: got %h expected no push", data_out);
        end else begin
          chk("push_word", data_out, exp_q.pop_front());
          chk("strb", {28'b0, strb_out}, 32'hF);
        end
      end
      // A new request may only follow a cycle in which the grant was low.
      if (req && !prev_req) chk("ack_low_before_req", {31'b0, prev_ack}, 32'h0);
    end
    prev_ack = ack;
    prev_req = req;
  end

  // Arbiter model: registered grant after ack_dly cycles of request,
  // optionally held stale for stale_extra cycles after the request drops.
  int age = 0;
  int stale_left = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      ack = 1'b0;
      age = 0;
    end else if (req) begin
      if (ack_en) begin
        if (age >= ack_dly && !ack) begin
          ack = 1'b1;
          stale_left = stale_extra;
        end
        age++;
      end
    end else begin
      age = 0;
      if (ack) begin
        if (stale_left > 0) stale_left--;
        else ack = 1'b0;
      end
    end
  end

  // Stream driver: offers in_q words with random gaps.
  bit take;
  initial forever begin
    @(negedge clk);
    take = s_valid && s_ready && rst_n;
    @(posedge clk);
    #1;
    if (take && in_q.size() > 0) begin
      void'(in_q.pop_front());
      fed++;
    end
    if (in_q.size() > 0 && fed < feed_limit && $urandom_range(99) >= gap_pct) begin
      s_valid = 1'b1;
      s_data  = in_q[0];
    end else begin
      s_valid = 1'b0;
      s_data  = $urandom;
    end
  end

  // Reference model: the whole frame's expected FIFO pushes, from the burst rules.
  task automatic model_frame(input logic [31:0] base, input int n, input logic [31:0] w[$]);
    logic [31:0] addr;
    int rem;
    int len;
    int k;
    addr = base;
    rem = n;
    k = 0;
    while (rem > 0) begin
      len = (rem > BST) ? BST : rem;
      exp_q.push_back({22'b0, (rem == len), 1'b0, 8'(len - 1)});
      exp_q.push_back(addr);
      for (int i = 0; i < len; i++) begin
        exp_q.push_back(bsw(w[k]));
        k++;
      end
      addr = addr + 32'(4 * len);
      rem = rem - len;
    end
  endtask

  task automatic launch(input logic [31:0] base, input int n, input logic [31:0] w[$]);
    model_frame(base, n, w);
    foreach (w[i]) in_q.push_back(w[i]);
    base_addr = base;
    num_words = 24'(n);
    start = 1'b1;
    step(1);
    start = 1'b0;
    base_addr = $urandom;
    num_words = 24'($urandom);
  endtask

  // mode 0: normal, 1: late 16th word, 2: grant withheld for 100 cycles
  task automatic run_frame(input logic [31:0] base, input int n, input int mode,
                           input logic [31:0] first_word, input bit use_first);
    logic [31:0] w[$];
    bit req_hi;
    int t;
    for (int i = 0; i < n; i++) w.push_back($urandom);
    if (use_first) w[0] = first_word;
    if (mode == 1) feed_limit = fed + 15;
    if (mode == 2) ack_en = 1'b0;
    launch(base, n, w);
    // done_in and start while busy must both be ignored.
    done_in = 1'b1;
    start = 1'b1;
    num_words = 24'd5;
    step(1);
    done_in = 1'b0;
    start = 1'b0;
    chk("no_done_on_stray_done_in", {31'b0, frm_done}, 32'h0);
    chk("busy_during_frame", {31'b0, busy}, 32'h1);
    if (mode == 1) begin
      t = 0;
      while (fed < feed_limit && t < 1000) begin step(1); t++; end
      if (t >= 1000) begin
        n_cmp++; n_bad++;
        $display("FAIL late_feed_timeout: got %0d words expected %0d", fed, feed_limit);
      end
      req_hi = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (req) req_hi = 1'b1;
        step(1);
      end
      chk("req_low_until_full_burst", {31'b0, req_hi}, 32'h0);
      feed_limit = 1 << 30;
    end
    if (mode == 2) begin
      step(100);
      chk("s_ready_low_when_full", {31'b0, s_ready}, 32'h0);
      chk("req_held_without_ack", {31'b0, req}, 32'h1);
      ack_en = 1'b1;
    end
    t = 0;
    while (exp_q.size() != 0 && t < 4000) begin step(1); t++; end
    if (t >= 4000) begin
      n_cmp++; n_bad++;
      $display("FAIL frame_timeout: got %0d pushes outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
    step($urandom_range(3));
    chk("busy_in_wait_done", {31'b0, busy}, 32'h1);
    done_in = 1'b1;
    step(1);
    done_in = 1'b0;
    chk("frm_done_pulse", {31'b0, frm_done}, 32'h1);
    chk("idle_after_done", {31'b0, busy}, 32'h0);
    step(1);
    chk("frm_done_one_cycle", {31'b0, frm_done}, 32'h0);
  endtask

  initial begin
    logic [31:0] w[$];
    int t;
    step(3);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_frm_done", {31'b0, frm_done}, 32'h0);
    chk("rst_req", {31'b0, req}, 32'h0);
    chk("rst_valid_out", {31'b0, valid_out}, 32'h0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_strb_out", {28'b0, strb_out}, 32'hF);
    chk("rst_s_ready", {31'b0, s_ready}, 32'h1);
    rst_n = 1'b1;
    step(2);

    // Zero-length start is ignored.
    base_addr = 32'h1234_0000;
    num_words = 24'd0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    chk("zero_len_ignored", {31'b0, busy}, 32'h0);

    ack_dly = 2; gap_pct = 0;
    run_frame(32'h1000_0000, 32, 0, 32'h0, 1'b0);
    gap_pct = 30;
    run_frame(32'h1000_0000, 20, 0, 32'h0, 1'b0);
    run_frame(32'h2000_0000, 1, 0, 32'h1122_3344, 1'b1);
    gap_pct = 0;
    run_frame(32'h3000_0100, 16, 1, 32'h0, 1'b0);
    run_frame(32'h4000_0000, 32, 2, 32'h0, 1'b0);
    stale_extra = 1;
    run_frame(32'h5000_0000, 40, 0, 32'h0, 1'b0);
    run_frame(32'hFFFF_FFC0, 37, 0, 32'h0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ack_dly = $urandom_range(1, 4);
      gap_pct = $urandom_range(0, 60);
      stale_extra = $urandom_range(0, 1);
      run_frame($urandom & 32'hFFFF_FFFC, $urandom_range(1, 50), 0, 32'h0, 1'b0);
    end

    // Reset in the middle of a data phase.
    ack_dly = 1; gap_pct = 0; stale_extra = 0;
    w.delete();
    for (int i = 0; i < 16; i++) w.push_back($urandom);
    launch(32'h6000_0000, 16, w);
    t = 0;
    while (exp_q.size() > 14 && t < 1000) begin step(1); t++; end
    if (t >= 1000) begin
      n_cmp++; n_bad++;
      $display("FAIL reset_setup_timeout: got %0d pushes outstanding expected 14", exp_q.size());
    end
    sb_on = 1'b0;
    rst_n = 1'b0;
    step(1);
    chk("midrst_req", {31'b0, req}, 32'h0);
    chk("midrst_valid_out", {31'b0, valid_out}, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_s_ready", {31'b0, s_ready}, 32'h1);
    exp_q.delete();
    in_q.delete();
    step(1);
    rst_n = 1'b1;
    step(1);
    sb_on = 1'b1;
    // Stale buffered words would show up as data mismatches here.
    run_frame(32'h7000_0000, 18, 0, 32'h0, 1'b0);

    step(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(600_000);
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frm_wr.md
# frm_wr

Frame write requester that sits directly upstream of the AXI arbiter. It accepts a 32-bit pixel/word stream into a local buffer and slices it into write bursts of at most `BST_LEN` words. For each burst it requests the arbiter, then pushes a command word, an address word and the burst data into the arbiter's shared frame FIFO. It reports frame completion when the arbiter signals that the last burst's write response has been received.

## Interface
Parameters:
- `BST_LEN`, 16: maximum burst length in words. Legal range is 1..256.
- `BUF_AW`, 9: local buffer address width. Depth is 2^BUF_AW words and must be ≥ BST_LEN.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  one-cycle frame start pulse. Sampled only in IDLE.
- `base_addr`  in  32  frame byte address. Must be 4-byte aligned.
- `num_words`  in  24  frame length in 32-bit words.
- `busy`  out  1  high whenever the state is not IDLE.
- `frm_done`  out  1  one-cycle pulse at frame completion.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  buffer not full.
- `s_data`  in  32  input word.
- `req`  out  1  arbiter request.
- `ack`  in  1  arbiter grant. It is registered by the arbiter and stays high while `req` stays high.
- `valid_out`  out  1  frame FIFO write enable.
- `data_out`  out  32  frame FIFO data.
- `strb_out`  out  4  frame FIFO byte strobe.
- `done_in`  in  1  arbiter completion pulse for this requester.

## Operation
- Buffer:
  - A word is written on `s_valid & s_ready`. A word is popped in DATA.
  - `buf_cnt` ranges 0..2^BUF_AW. A simultaneous push and pop leaves it unchanged.
  - `s_ready = (buf_cnt != 2^BUF_AW)`. Input words are accepted in every state, including IDLE.
- States and transitions:
  - IDLE → FILL on `start & (num_words != 0)`. On that transition, latch `cur_addr = base_addr` and `remaining = num_words`. `start` with `num_words == 0` is ignored.
  - FILL → REQ when `buf_cnt >= cur_len` and `ack == 0`. The `ack == 0` condition prevents reuse of a stale grant. `cur_len = min(BST_LEN, remaining)`.
  - REQ: hold `req` high. Go to CMD when `ack == 1`.
  - CMD: push command word `{22'b0, last, 1'b0, cur_len-1}`, where `last = (remaining == cur_len)`. Go to ADDR.
  - ADDR: push `cur_addr`. Go to DATA.
  - DATA: pop and push one word per cycle, `cur_len` words in total. After the final word:
    - Update `cur_addr += 4*cur_len` (32-bit arithmetic, wraps modulo 2^32).
    - Update `remaining -= cur_len`.
    - Go to WAIT_DONE if `remaining == 0`, otherwise to FILL.
  - WAIT_DONE → IDLE on `done_in`. Pulse `frm_done` on the same transition.
- `req` is high in REQ, CMD, ADDR and DATA only. It drops in the cycle after the final data word is pushed.
- `strb_out` is 4'hF for every word pushed.
- `done_in` outside WAIT_DONE is ignored. `start` outside IDLE is ignored.
- No backpressure from the frame FIFO: pushes are unconditional, and overflow is the arbiter's to flag.

## Timing
- Reset values: `busy` 0, `frm_done` 0, `req` 0, `valid_out` 0, `data_out` 0, `strb_out` 4'hF, `s_ready` 1. The state returns to IDLE and `buf_cnt` to 0.
- Reset mid-burst: outputs return to reset values on the next edge and buffered data is discarded.
- Outputs `req`, `valid_out`, `data_out` and `strb_out` are registered.
- Latency: `ack` first sampled high at edge N gives:
  - `valid_out` high with the command word at N+1,
  - the address word at N+2,
  - data words at N+3 … N+2+cur_len.
- `valid_out` is continuous, with no gaps, from the command word through the last data word of a burst.
- `req` rises at least 1 cycle after the previous burst's `ack` is seen low.
- The final partial burst (num_words not a multiple of BST_LEN) has `cur_len = remaining` and `last = 1`.
- A single-word frame produces 3 pushes.

## Configuration
- `FRM_WR_BSWAP_EN`:
  - Defined: each data word is byte-swapped on the way out, `data_out = {d[7:0], d[15:8], d[23:16], d[31:24]}`. Command and address words are never swapped.
  - Undefined: data passes unchanged.

## Test plan
- Basic frame: `base_addr` 0x1000_0000, `num_words` 32, BST_LEN 16, 32 words streamed, `ack` 2 cycles after `req`.
  - Required: two bursts. Commands 0x00F then 0x20F, addresses 0x1000_0000 then 0x1000_0040, data in input order. `frm_done` pulses 1 cycle after `done_in`.
- Partial last burst: `num_words` 20.
  - Required: commands 0x00F then 0x203, second address base+0x40, 4 data words.
- Late data: feed 15 words, pause 50 cycles, then feed the 16th.
  - Required: `req` stays low until `buf_cnt` reaches 16.
- Buffer full: BUF_AW 4, no `ack` for 100 cycles, `s_valid` held high.
  - Required: `s_ready` goes low at 16 words. No word is lost or duplicated after `ack`.
- Stale ack and reset: `ack` held high one extra cycle after `req` drops.
  - Required: the next REQ waits for `ack` to go low and no duplicate command word is pushed.
  - Then assert `rst_n` low mid-DATA. Required: `req`, `valid_out` and `busy` read 0 on the next edge.
- Macro defined: data word 0x1122_3344.
  - Required: `data_out` is 0x4433_2211. The address word is unchanged.
